cdc_pulse_sched: RTL

CDC_PULSE_SCHED -- requirements
Module: cdc_pulse_sched

---
 rtl/cdc_pulse_sched_pkg.sv | 16 +
 rtl/cdc_pulse_sched_sat_cnt.sv | 37 +++
 rtl/cdc_pulse_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cdc_pulse_sched_pkg.sv
// Shared types and defaults for the pulse scheduler in front of a CDC pulse bridge.
package cdc_pulse_pkg;

  // Handshake FSM: IDLE can issue, WAIT_SET waits for the bridge to go busy,
  // WAIT_CLR waits for it to go idle again.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SET = 2'd1,
    WAIT_CLR = 2'd2
  } state_e;

  localparam int DEF_CNT_W   = 4;
  localparam int DEF_TMO_CYC = 1024;
  localparam int TMO_W       = 16;

endpackage

// File: rtl/cdc_pulse_sched_sat_cnt.sv
// Saturating up-counter with synchronous clear; a clear that coincides with an
// increment leaves the counter at 1 so the coincident event is not lost.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         s_clk,
  input  logic         s_rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count: clear wins over hold, increment stops at all-ones.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = inc ? W'(1) : '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge s_clk or negedge s_rstn) begin
    if (!s_rstn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cdc_pulse_sched.sv
// Queues single-cycle event requests and feeds them one at a time into a pulse
// bridge, waiting for each bridge busy cycle (set then clear) before the next.
// A stuck handshake is abandoned after TMO_CYC cycles and flagged in tmo_err.
module cdc_pulse_sched
  import cdc_pulse_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic             s_clk,
  input  logic             s_rstn,
  input  logic             in_pls,
  output logic             out_vld,
  input  logic             br_active,
  output logic [CNT_W-1:0] pending,
  output logic             full,
  output logic [7:0]       drop_cnt,
  output logic             busy,
  output logic             tmo_err,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_e           state_q;
  state_e           state_d;
  logic             out_vld_q;
  logic             out_vld_d;
  logic [CNT_W-1:0] pending_q;
  logic [CNT_W-1:0] pending_d;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;
  logic             tmo_err_q;
  logic             tmo_err_d;

  logic             issue;
  logic             accept;
  logic             drop;
  logic             tmo_hit;
  logic             tmo_fire;

  // Queue bookkeeping: an issue on the same edge frees a slot, so a request
  // arriving while full is still accepted when an issue coincides with it.
  always_comb begin
    issue     = (state_q == IDLE) && (pending_q != '0) && !br_active;
    accept    = in_pls && ((pending_q != PEND_MAX) || issue);
    drop      = in_pls && !accept;
    pending_d = pending_q;
    if (accept && !issue) begin
      pending_d = pending_q + CNT_W'(1);
    end else if (issue && !accept) begin
      pending_d = pending_q - CNT_W'(1);
    end
  end

  // Handshake sequencing and timeout; a completed handshake in WAIT_CLR takes
  // precedence over a timeout on the same edge. A timed-out event is gone.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    tmo_hit   = (tmo_q == TMO_LAST);
    tmo_fire  = 1'b0;
    out_vld_d = issue;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (issue) begin
          state_d = WAIT_SET;
        end
      end
      WAIT_SET: begin
        if (tmo_hit) begin
          state_d  = IDLE;
          tmo_fire = 1'b1;
          tmo_d    = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (br_active) begin
            state_d = WAIT_CLR;
          end
        end
      end
      WAIT_CLR: begin
        if (!br_active) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else if (tmo_hit) begin
          state_d  = IDLE;
          tmo_fire = 1'b1;
          tmo_d    = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tmo_d   = '0;
      end
    endcase
    // A new timeout wins over a coincident clear so the event is reported.
    if (tmo_fire) begin
      tmo_err_d = 1'b1;
    end else if (err_clr) begin
      tmo_err_d = 1'b0;
    end else begin
      tmo_err_d = tmo_err_q;
    end
  end

  // FSM, queue and flag registers.
  always_ff @(posedge s_clk or negedge s_rstn) begin
    if (!s_rstn) begin
      state_q   <= IDLE;
      out_vld_q <= 1'b0;
      pending_q <= '0;
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_vld_q <= out_vld_d;
      pending_q <= pending_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  sat_cnt #(
    .W (8)
  ) u_drop_cnt (
    .s_clk  (s_clk),
    .s_rstn (s_rstn),
    .inc    (drop),
    .clr    (err_clr),
    .q      (drop_cnt)
  );

  assign out_vld = out_vld_q;
  assign pending = pending_q;
  assign full    = (pending_q == PEND_MAX);
  assign busy    = (state_q != IDLE) || (pending_q != '0);
  assign tmo_err = tmo_err_q;

endmodule
